// File: rtl/i2c_cond_generator.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cond_generator
// Description : Master-side I2C START / repeated START / STOP generator with
//               SCL clock-stretch support on every SCL-release phase.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cond_generator #(
  parameter int HALF_CNT = 8,
  parameter int CNT_W    = $clog2(HALF_CNT)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Cmd_Valid,
  input  logic [1:0] Cmd,
  output logic       Cmd_Ready,
  input  logic       SCL_I,
  output logic       SDA_O,
  output logic       SCL_O,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic       Bus_Owned
);

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(HALF_CNT - 1);
  localparam logic [1:0]       CMD_START  = 2'b01;
  localparam logic [1:0]       CMD_STOP   = 2'b10;
  localparam logic [1:0]       CMD_RSTART = 2'b11;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    S1   = 4'd1,  S2 = 4'd2,  S3 = 4'd3,
    R1   = 4'd4,  R2 = 4'd5,  R3 = 4'd6,  R4 = 4'd7,
    P1   = 4'd8,  P2 = 4'd9,  P3 = 4'd10, P4 = 4'd11
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             scl_meta;
  logic             scl_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      scl_meta  <= 1'b1;
      scl_s     <= 1'b1;
      SDA_O     <= 1'b1;
      SCL_O     <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      Bus_Owned <= 1'b0;
      Cmd_Ready <= 1'b1;
    end else begin
      scl_meta <= SCL_I;
      scl_s    <= scl_meta;
      Done     <= 1'b0;
      Error    <= 1'b0;
      case (state)
        IDLE: begin
          if (Cmd_Valid && Cmd_Ready && (Cmd != 2'b00)) begin
            cnt <= CNT_LOAD;
            // A START while the bus is already held becomes a repeated START.
            if ((Cmd == CMD_RSTART) || ((Cmd == CMD_START) && Bus_Owned)) begin
              state     <= R1;
              SDA_O     <= 1'b1;
              SCL_O     <= 1'b0;
              Busy      <= 1'b1;
              Cmd_Ready <= 1'b0;
            end else if (Cmd == CMD_START) begin
              state     <= S1;
              SDA_O     <= 1'b1;
              SCL_O     <= 1'b1;
              Busy      <= 1'b1;
              Cmd_Ready <= 1'b0;
            end else if (Bus_Owned) begin
              state     <= P1;
              SDA_O     <= 1'b0;
              SCL_O     <= 1'b0;
              Busy      <= 1'b1;
              Cmd_Ready <= 1'b0;
            end else begin
              Error <= 1'b1;
            end
          end
        end
        S1: begin
          if (cnt == '0) begin
            state <= S2;
            cnt   <= CNT_LOAD;
            SDA_O <= 1'b0;
          end else cnt <= cnt - 1'b1;
        end
        S2: begin
          if (cnt == '0) begin
            state     <= S3;
            SCL_O     <= 1'b0;
            Done      <= 1'b1;
            Bus_Owned <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        R1: begin
          if (cnt == '0) begin
            state <= R2;
            cnt   <= CNT_LOAD;
            SCL_O <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        R2: begin
          // The phase only runs while SCL is seen high, so a stretching slave extends it.
          if (cnt == '0) begin
            state <= R3;
            cnt   <= CNT_LOAD;
            SDA_O <= 1'b0;
          end else if (scl_s) cnt <= cnt - 1'b1;
        end
        R3: begin
          if (cnt == '0) begin
            state     <= R4;
            SCL_O     <= 1'b0;
            Done      <= 1'b1;
            Bus_Owned <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        P1: begin
          if (cnt == '0) begin
            state <= P2;
            cnt   <= CNT_LOAD;
            SCL_O <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        P2: begin
          if (cnt == '0) begin
            state <= P3;
            cnt   <= CNT_LOAD;
            SDA_O <= 1'b1;
          end else if (scl_s) cnt <= cnt - 1'b1;
        end
        P3: begin
          if (cnt == '0) begin
            state     <= P4;
            Done      <= 1'b1;
            Bus_Owned <= 1'b0;
          end else cnt <= cnt - 1'b1;
        end
        S3, R4, P4: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          Cmd_Ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          Cmd_Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/i2c_cond_generator.md
Name: i2c_cond_generator

Overview:
- Master-side generator of I2C bus conditions: START, repeated START and STOP on open-drain SDA/SCL, with timing set by a half-period cycle count.
- Complements the slave-side start/stop detector: every condition produced here is one that detector reports.
- Sits between the I2C master byte controller (command source) and the pad open-drain drivers.
- Honours clock stretching on every SCL-release phase.

Parameters:
- HALF_CNT, 8, CLK cycles per timed phase (half SCL period); legal range ≥2.
- CNT_W, $clog2(HALF_CNT), width of the phase counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- Cmd_Valid  input  1  command request.
- Cmd  input  2  01=START, 10=STOP, 11=repeated START, 00=ignored.
- Cmd_Ready  output  1  high only in IDLE; a command is accepted when Cmd_Valid & Cmd_Ready & Cmd!=00.
- SCL_I  input  1  raw SCL pad level, used for stretch detection.
- SDA_O  output  1  SDA drive: 0=pull low, 1=release.
- SCL_O  output  1  SCL drive: 0=pull low, 1=release.
- Busy  output  1  high while a sequence is running.
- Done  output  1  one-cycle pulse in the last cycle of a sequence.
- Error  output  1  one-cycle pulse when a STOP is requested while the bus is not owned.
- Bus_Owned  output  1  set by START/repeated START completion, cleared by STOP completion.

Behaviour:
- Reset values (asynchronous, RST=1): SDA_O=1, SCL_O=1, Busy=0, Done=0, Error=0, Bus_Owned=0, Cmd_Ready=1, state=IDLE, counter=0, SCL synchroniser=11.
  - Reset mid-sequence releases both lines immediately; the sequence is abandoned.
- All outputs are registered.
- SCL_I passes through a 2-flop synchroniser (scl_s).
- Timed phase: on entry, counter loads HALF_CNT-1; it decrements each cycle; the state advances on the cycle after the counter reaches 0. Each timed phase lasts exactly HALF_CNT cycles.
- SCL-release phases (marked *):
  - The counter holds at HALF_CNT-1 while scl_s=0 and decrements only while scl_s=1.
  - With SCL_I tied to SCL_O, the phase lasts HALF_CNT+2 cycles.
  - A stretch adds one cycle per extra low cycle.
- Command dispatch from IDLE:
  - START with Bus_Owned=0 → S1.
  - START with Bus_Owned=1 → R1 (executed as a repeated start).
  - RSTART → R1 regardless of Bus_Owned.
  - STOP with Bus_Owned=1 → P1.
  - STOP with Bus_Owned=0 → Error=1 for one cycle, stay IDLE, lines untouched.
  - Cmd=00 → no action.
  - Busy rises on the cycle after acceptance.
- START sequence:
  - S1 (SDA=1, SCL=1, timed): setup.
  - S2 (SDA=0, SCL=1, timed): hold; the SDA fall occurs while SCL is high.
  - S3 (SDA=0, SCL=0, 1 cycle, Done=1, Bus_Owned←1).
  - Then IDLE.
- Repeated START sequence:
  - R1 (SDA=1, SCL=0, timed).
  - R2* (SDA=1, SCL=1).
  - R3 (SDA=0, SCL=1, timed).
  - R4 (SDA=0, SCL=0, 1 cycle, Done=1, Bus_Owned←1).
  - Then IDLE.
- STOP sequence:
  - P1 (SDA=0, SCL=0, timed).
  - P2* (SDA=0, SCL=1).
  - P3 (SDA=1, SCL=1, timed): bus-free time.
  - P4 (SDA=1, SCL=1, 1 cycle, Done=1, Bus_Owned←0).
  - Then IDLE.
- Line levels in IDLE:
  - After START/RSTART: SDA_O=0, SCL_O=0 (held until the next command).
  - After STOP or reset: both released.
- Command handling during a sequence: Cmd_Valid is ignored (not queued). Cmd_Ready=0 from acceptance through the Done cycle, and returns to 1 the cycle after Done.
- Line transition rules:
  - SDA changes only while SCL_O=0, except the deliberate S2/R3 fall and the P3 rise.
  - Outputs never change SDA_O and SCL_O in the same cycle.
- Stretch with no upper bound: the generator waits indefinitely in R2/P2 (no timeout in this block).

Test Plan:
- HALF_CNT=4, SCL_I=SCL_O, START from reset → SDA_O falls 4 cycles after Busy rises; SCL_O falls 4 cycles later; Done in that cycle; Busy high 9 cycles; Bus_Owned=1; lines 0/0 in IDLE.
- After START, issue STOP → SDA_O=0/SCL_O=0 for 4 cycles; SCL_O rises, SDA_O rises 6 cycles later; Done 4 cycles after that; Bus_Owned=0; lines 1/1.
- STOP issued right after reset → Error pulse 1 cycle; Busy stays 0; SDA_O/SCL_O stay 1.
- After START, repeated START with SCL_I forced low for 10 cycles after SCL_O rises → R2 lasts 16 cycles; the SDA fall occurs with SCL_O=1; Done pulses; Bus_Owned stays 1.
- Assert RST during S2 → SDA_O=1, SCL_O=1, Busy=0, Bus_Owned=0 asynchronously (before the next CLK edge); the next START runs a full S1–S3.
- Cmd_Valid held high with Cmd=01 throughout a START → exactly one START executes. The new request is taken the cycle after Done: Bus_Owned=1 at that point, so it executes as a repeated START (R1 entered).
